// File: rtl/apb_alarm_master_if.sv
// Command/response stream plus APB4 bus bundle seen by apb_alarm_master.
interface apb_alarm_master_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [31:0]       cmd_wdata_i;
  logic [3:0]        cmd_strb_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;

  logic [ADDR_W-1:0] paddr_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [31:0]       pwdata_o;
  logic [3:0]        pstrb_o;
  logic              pready_i;
  logic [31:0]       prdata_i;
  logic              pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
           rsp_ready_i, pready_i, prdata_i, pslverr_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
           paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
           rsp_ready_i, pready_i, prdata_i, pslverr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
           paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/apb_alarm_master.sv
// APB4 initiator: one command in, one single APB transfer out, one response back,
// with a pready watchdog so a hung slave cannot stall the command stream.
module apb_alarm_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                pclk_i,
  input logic                presetn_i,
  apb_alarm_master_if.master bus
);
  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            r_state;
  state_e            w_next_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              w_timeout;
  logic              w_cmd_ready;
  logic              w_psel;
  logic              w_penable;
  logic              w_rsp_valid;

  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [31:0]       r_pwdata;
  logic [3:0]        r_pstrb;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  // Timeout fires on the ACCESS cycle that would be the TIMEOUT_CYCLES-th unanswered one.
  assign w_timeout = (r_state == S_ACCESS) && !bus.pready_i && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.cmd_valid_i) w_next_state = S_SETUP;
      S_SETUP:  w_next_state = S_ACCESS;
      S_ACCESS: if (bus.pready_i || w_timeout) w_next_state = S_RESP;
      S_RESP:   if (bus.rsp_ready_i) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // cmd_ready is gated by reset so it reads 0 while presetn_i is held low.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_rsp_valid = 1'b0;
    unique case (r_state)
      S_IDLE:   w_cmd_ready = presetn_i;
      S_SETUP:  w_psel      = 1'b1;
      S_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      S_RESP:   w_rsp_valid = 1'b1;
      default:  w_cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ACCESS) begin
      if (!bus.pready_i) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // APB request fields load only on acceptance; response fields only on ACCESS completion.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && bus.cmd_valid_i) begin
        r_paddr  <= bus.cmd_addr_i;
        r_pwrite <= bus.cmd_write_i;
        r_pwdata <= bus.cmd_write_i ? bus.cmd_wdata_i : 32'h0;
        r_pstrb  <= bus.cmd_write_i ? bus.cmd_strb_i  : 4'h0;
      end
      if (r_state == S_ACCESS) begin
        if (bus.pready_i) begin
          r_rsp_rdata   <= r_pwrite ? 32'h0 : bus.prdata_i;
          r_rsp_err     <= bus.pslverr_i;
          r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_rdata   <= 32'h0;
          r_rsp_err     <= 1'b1;
          r_rsp_timeout <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready_o   = w_cmd_ready;
  assign bus.psel_o        = w_psel;
  assign bus.penable_o     = w_penable;
  assign bus.rsp_valid_o   = w_rsp_valid;
  assign bus.paddr_o       = r_paddr;
  assign bus.pwrite_o      = r_pwrite;
  assign bus.pwdata_o      = r_pwdata;
  assign bus.pstrb_o       = r_pstrb;
  assign bus.rsp_rdata_o   = r_rsp_rdata;
  assign bus.rsp_err_o     = r_rsp_err;
  assign bus.rsp_timeout_o = r_rsp_timeout;
endmodule

// File: tb/tb_apb_alarm_master.sv
// Randomized scoreboard bench for apb_alarm_master with a reactive APB slave model.
module tb_apb_alarm_master;
  localparam int unsigned ADDR_W = 32;
  localparam int          TMO    = 16;
  localparam int          HANG   = 1 << 20;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          acc;
  } apb_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_exp_t;

  typedef struct {
    int          wait_n;
    logic [31:0] rdata;
    logic        err;
  } slv_cfg_t;

  logic clk = 1'b0;
  logic rst_n;

  apb_exp_t exp_apb[$];
  rsp_exp_t exp_rsp[$];
  slv_cfg_t slv_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int force_stall = -1;
  int rdy_stall_total = 0;
  int rdy_stall_left  = 0;
  bit orphan_en = 1'b0;

  apb_alarm_master_if #(.ADDR_W(ADDR_W)) bus ();

  apb_alarm_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk_i    (clk),
    .presetn_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Reference model: expected APB shape and response derived from the slave's wait count.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int wait_n, input logic [31:0] rdata,
                          input logic err);
    apb_exp_t a;
    rsp_exp_t r;
    slv_cfg_t s;
    bit       tmo;
    int       n;
    tmo     = (wait_n >= TMO);
    a.write = wr;
    a.addr  = addr;
    a.wdata = wr ? wdata : 32'h0;
    a.strb  = wr ? strb  : 4'h0;
    a.acc   = tmo ? TMO : wait_n + 1;
    r.tmo   = tmo;
    r.err   = tmo ? 1'b1 : err;
    r.rdata = (tmo || wr) ? 32'h0 : rdata;
    s.wait_n = wait_n;
    s.rdata  = rdata;
    s.err    = err;
    exp_apb.push_back(a);
    exp_rsp.push_back(r);
    slv_q.push_back(s);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    bus.cmd_strb_i  = strb;
    n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      fail_now("cmd_accept_timeout");
      bus.cmd_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'($urandom_range(0, 1));
    bus.cmd_addr_i  = $urandom;
    bus.cmd_wdata_i = $urandom;
    bus.cmd_strb_i  = 4'($urandom_range(0, 15));
    #1;
    check("setup_psel", 64'(bus.psel_o), 64'(1));
    check("setup_penable", 64'(bus.penable_o), 64'(0));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_rsp.size() != 0 || exp_apb.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_rsp.size() + exp_apb.size()), 64'(0));
  endtask

  // APB slave: answers after wait_n unready ACCESS cycles, junk on every ignored input.
  always @(negedge clk) begin : slave
    static slv_cfg_t s_cfg;
    static bit       s_active = 1'b0;
    static int       s_cyc    = 0;
    if (rst_n !== 1'b1) begin
      s_active     = 1'b0;
      s_cyc        = 0;
      bus.pready_i = 1'b0;
    end else if (bus.psel_o && bus.penable_o) begin
      if (!s_active) begin
        if (slv_q.size() != 0) s_cfg = slv_q.pop_front();
        else begin
          s_cfg.wait_n = 0;
          s_cfg.rdata  = 32'h0;
          s_cfg.err    = 1'b0;
        end
        s_active = 1'b1;
        s_cyc    = 0;
      end
      if (s_cyc == s_cfg.wait_n) begin
        bus.pready_i  = 1'b1;
        bus.prdata_i  = s_cfg.rdata;
        bus.pslverr_i = s_cfg.err;
      end else begin
        bus.pready_i  = 1'b0;
        bus.prdata_i  = $urandom;
        bus.pslverr_i = 1'($urandom_range(0, 1));
      end
      s_cyc++;
    end else begin
      s_active      = 1'b0;
      bus.pready_i  = 1'($urandom_range(0, 1));
      bus.prdata_i  = $urandom;
      bus.pslverr_i = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin : rsp_sink
    if (bus.rsp_valid_o !== 1'b1) begin
      bus.rsp_ready_i = 1'($urandom_range(0, 1));
      rdy_stall_total = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
      rdy_stall_left  = rdy_stall_total;
    end else if (rdy_stall_left > 0) begin
      bus.rsp_ready_i = 1'b0;
      rdy_stall_left--;
    end else begin
      bus.rsp_ready_i = 1'b1;
    end
  end

  initial begin : monitor
    logic        m_in, m_write, m_err, m_tmo;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;
    int          m_psel_n, m_pen_n, m_rsp_n;
    bit          m_unstable, m_proto, m_rsp_unstable, m_rsp_block;
    apb_exp_t    a;
    rsp_exp_t    r;
    m_in = 1'b0;
    m_rsp_n = 0;
    m_rsp_unstable = 1'b0;
    m_rsp_block = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        m_in = 1'b0;
        m_rsp_n = 0;
        m_rsp_unstable = 1'b0;
        m_rsp_block = 1'b0;
      end else begin
        if (bus.penable_o && !bus.psel_o) orphan_en = 1'b1;
        if (bus.psel_o) begin
          if (!m_in) begin
            m_in = 1'b1;
            m_addr = bus.paddr_o; m_write = bus.pwrite_o;
            m_wdata = bus.pwdata_o; m_strb = bus.pstrb_o;
            m_psel_n = 0; m_pen_n = 0;
            m_unstable = 1'b0;
            m_proto = bus.penable_o;
          end else if (bus.paddr_o !== m_addr || bus.pwrite_o !== m_write ||
                       bus.pwdata_o !== m_wdata || bus.pstrb_o !== m_strb) begin
            m_unstable = 1'b1;
          end
          m_psel_n++;
          if (bus.penable_o) m_pen_n++;
        end else if (m_in) begin
          m_in = 1'b0;
          if (exp_apb.size() == 0) fail_now("apb_unexpected_transfer");
          else begin
            a = exp_apb.pop_front();
            check("paddr", 64'(m_addr), 64'(a.addr));
            check("pwrite", 64'(m_write), 64'(a.write));
            check("pwdata", 64'(m_wdata), 64'(a.wdata));
            check("pstrb", 64'(m_strb), 64'(a.strb));
            check("psel_cycles", 64'(m_psel_n), 64'(a.acc + 1));
            check("penable_cycles", 64'(m_pen_n), 64'(a.acc));
            check("apb_fields_stable", 64'(m_unstable), 64'(0));
            check("penable_in_first_psel", 64'(m_proto), 64'(0));
            check("rsp_follows_transfer", 64'(bus.rsp_valid_o), 64'(1));
          end
        end
        if (bus.rsp_valid_o) begin
          if (m_rsp_n == 0) begin
            m_rdata = bus.rsp_rdata_o; m_err = bus.rsp_err_o; m_tmo = bus.rsp_timeout_o;
          end else if (bus.rsp_rdata_o !== m_rdata || bus.rsp_err_o !== m_err ||
                       bus.rsp_timeout_o !== m_tmo) begin
            m_rsp_unstable = 1'b1;
          end
          if (bus.cmd_ready_o || bus.psel_o) m_rsp_block = 1'b1;
          m_rsp_n++;
          if (bus.rsp_ready_i) begin
            if (exp_rsp.size() == 0) fail_now("rsp_unexpected");
            else begin
              r = exp_rsp.pop_front();
              check("rsp_rdata", 64'(m_rdata), 64'(r.rdata));
              check("rsp_err", 64'(m_err), 64'(r.err));
              check("rsp_timeout", 64'(m_tmo), 64'(r.tmo));
              check("rsp_stable", 64'(m_rsp_unstable), 64'(0));
              check("no_cmd_during_rsp", 64'(m_rsp_block), 64'(0));
              check("rsp_hold_cycles", 64'(m_rsp_n), 64'(rdy_stall_total + 1));
            end
            m_rsp_n = 0;
            m_rsp_unstable = 1'b0;
            m_rsp_block = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int          wait_n;
    logic [31:0] addr;
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.cmd_strb_i  = '0;
    #1;
    check("reset_psel", 64'(bus.psel_o), 64'(0));
    check("reset_penable", 64'(bus.penable_o), 64'(0));
    check("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check("reset_cmd_ready", 64'(bus.cmd_ready_o), 64'(0));
    check("reset_paddr", 64'(bus.paddr_o), 64'(0));
    check("reset_rsp_timeout", 64'(bus.rsp_timeout_o), 64'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("post_reset_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));

    send_cmd(1'b1, 32'h0, 32'h0001_1052, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);
    send_cmd(1'b0, 32'h8, 32'h1234_5678, 4'hF, 3, 32'h0001_1100, 1'b0);
    send_cmd(1'b1, 32'h10, 32'hCAFE_0001, 4'h3, 0, 32'h0, 1'b1);
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0, HANG, 32'h5555_AAAA, 1'b0);
    send_cmd(1'b0, 32'hC, 32'h0, 4'h0, TMO - 1, 32'hA5A5_0001, 1'b0);
    wait_drain();

    force_stall = 5;
    send_cmd(1'b1, 32'h4, 32'h0000_0042, 4'hF, 0, 32'h0, 1'b0);
    send_cmd(1'b0, 32'hC, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0);
    wait_drain();
    force_stall = -1;

    send_cmd(1'b0, 32'h4, 32'h0, 4'h0, 8, 32'h1111_2222, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_psel", 64'(bus.psel_o), 64'(0));
    check("midreset_penable", 64'(bus.penable_o), 64'(0));
    check("midreset_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
    check("midreset_cmd_ready", 64'(bus.cmd_ready_o), 64'(0));
    exp_apb.delete();
    exp_rsp.delete();
    slv_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("midreset_release_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
    send_cmd(1'b0, 32'h8, 32'h0, 4'h0, 1, 32'h0001_2345, 1'b0);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       addr = 32'h0;
        1:       addr = 32'h4;
        2:       addr = 32'h8;
        3:       addr = 32'hC;
        default: addr = $urandom & 32'hFFFF_FFFC;
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: wait_n = int'($urandom_range(0, 3));
        6, 7, 8:          wait_n = int'($urandom_range(TMO - 2, TMO + 1));
        default:          wait_n = HANG;
      endcase
      send_cmd(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
               wait_n, $urandom, 1'($urandom_range(0, 4) == 0));
    end
    wait_drain();

    check("penable_without_psel", 64'(orphan_en), 64'(0));
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_alarm_master.md
Name: apb_alarm_master

Overview:
APB4 initiator that converts a simple valid/ready command stream into single APB transfers toward apb_alarm or any APB slave. Used on-chip by the sequencer or CPU-less control logic to program TIME_INIT (0x0), TIME_ALARM (0x4), ALARM_OFF (0xC) and to read TIME_NOW (0x8). Returns read data and error status on a valid/ready response channel, and guards against a hung slave with a pready timeout.

Parameters:
ADDR_W, 32, APB address width
TIMEOUT_CYCLES, 1024, max ACCESS-phase cycles waiting for pready_i before aborting (>=1)

Ports:
pclk_i  in  1  clock
presetn_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted this cycle
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  target address
cmd_wdata_i  in  32  write data
cmd_strb_i  in  4  byte strobes (writes only)
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  32  read data (0 for writes)
rsp_err_o  out  1  pslverr_i or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
paddr_o  out  ADDR_W  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  32  APB write data
pstrb_o  out  4  APB strobes
pready_i  in  1  slave ready
prdata_i  in  32  slave read data
pslverr_i  in  1  slave error

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, except cmd_ready_o = 1 once presetn_i is high. Outputs take reset values combinationally with presetn_i low, not at the next edge.
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - cmd_ready_o=1, psel_o=0, penable_o=0.
  - On cmd_valid_i&&cmd_ready_o: register addr/write/wdata/strb onto the APB outputs and go to SETUP.
  - For reads, pstrb_o=0 and pwdata_o=0.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0, cmd_ready_o=0.
- ACCESS:
  - psel_o=1, penable_o=1.
  - paddr/pwrite/pwdata/pstrb are held stable for the whole transfer.
  - Wait counter starts at 0 on entry and increments each cycle pready_i=0.
  - pready_i=1 at an edge: capture rdata (prdata_i for reads, 0 for writes), rsp_err_o=pslverr_i, rsp_timeout_o=0; drop psel/penable; go to RESP.
  - Counter reaching TIMEOUT_CYCLES with pready_i still 0: drop psel/penable; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; go to RESP.
  - pready_i takes priority over timeout on the same cycle.
- RESP:
  - rsp_valid_o=1; rsp_* held stable until rsp_ready_i=1, then IDLE.
  - cmd_ready_o=0 while in RESP, so there is only one outstanding transfer.
- Latency: command accepted at edge N -> SETUP cycle N..N+1 -> ACCESS from N+1 -> with zero wait states, rsp_valid_o=1 after edge N+2. Minimum 4 cycles per transfer including the IDLE handshake.
- Outside a transfer, paddr/pwrite/pwdata/pstrb keep their last values; psel_o=0 and penable_o=0 always in IDLE/RESP.
- pslverr_i and prdata_i are sampled only at the completing ACCESS edge and ignored elsewhere.
- Reset mid-transfer aborts without producing a response; psel_o falls asynchronously.
- Never assert penable_o without psel_o; never assert penable_o in the first cycle of psel_o.

Test Plan:
- Zero-wait write: cmd write addr 0x0, data 0x00011052, strb 0xF, slave pready_i=1 always -> psel_o high 2 cycles, penable_o high 1 cycle, pwdata_o=0x00011052, rsp_valid_o with rsp_err_o=0, rsp_rdata_o=0.
- Wait-state read: cmd read addr 0x8, slave holds pready_i=0 for 3 ACCESS cycles then returns prdata_i=0x00011100 -> penable_o high 4 cycles, pstrb_o=0, rsp_rdata_o=0x00011100, rsp_err_o=0.
- Slave error: write to addr 0x10, slave returns pready_i=1 with pslverr_i=1 -> rsp_err_o=1, rsp_timeout_o=0.
- Timeout: TIMEOUT_CYCLES=16, slave never asserts pready_i -> after 16 ACCESS cycles psel_o/penable_o=0, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
- Backpressure: rsp_ready_i low for 5 cycles after rsp_valid_o, second command pending -> rsp_* stable, cmd_ready_o=0 until rsp_ready_i, no new psel_o; second command issues only afterwards.
- Reset mid-ACCESS: drop presetn_i during wait state -> psel_o, penable_o, rsp_valid_o go to 0 immediately; after release, cmd_ready_o=1 and the next read of 0x8 completes normally.
